fetch_unit: RTL and testbench



---
 rtl/core_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 567 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: data width, instruction field positions,
// fetch FSM encoding and the fetch buffer entry layout.
package core_pkg;

   localparam int XLEN = 32;

   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 6;
   localparam int F3_LSB  = 12;
   localparam int F3_MSB  = 14;

   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_BOOT     = 2'd0,
      FS_RUN      = 2'd1,
      FS_REDIRECT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(
      input logic [XLEN-1:0] a
   );
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
// master: fetch side (drives requests), slave: memory side.
interface fetch_unit_if;
   import core_pkg::*;

   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_req_ready;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} fetch entries.
// Ports: push/push_data, pop, flush (beats push), head/head_valid, count.
module fetch_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     head_valid,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          wr_en;
   logic          rd_en;

   assign wr_en = push & ~flush;
   assign rd_en = pop & ~flush & head_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   // Empty head reads as zero so the decoder sees a clean bundle.
   assign head_valid = (count != '0);
   assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credited in-order fetches,
// buffers returned words and squashes wrong-path fetches on redirect.
// Ports: clk/rst_n, imem bus (master), pc_src/pc_target redirect,
// instr_* head bundle with opcode/funct3 and instr_ready consume.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   fetch_unit_if.master    imem,
   input  logic            pc_src,
   input  logic [XLEN-1:0] pc_target,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus4,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   input  logic            instr_ready
);

   localparam int CW  = $clog2(BUF_DEPTH) + 1;
   localparam int CW1 = CW + 1;

   fetch_state_e    state;
   fetch_state_e    state_nxt;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   inflight_nxt;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   fifo_count;
   logic            pop;
   logic            redir;
   logic            credit_ok;
   logic            req_valid;
   logic            req_fire;
   logic            rsp_drop;
   logic            push;
   fetch_entry_t    head;

   assign pop   = instr_valid & instr_ready;
   assign redir = pop & pc_src;

   // Outstanding requests plus buffered words never exceed the buffer.
   assign credit_ok =
      ({1'b0, inflight} + {1'b0, fifo_count}) < CW1'(BUF_DEPTH);

   always_comb begin
      state_nxt = state;
      req_valid = 1'b0;
      unique case (state)
         FS_BOOT: state_nxt = FS_RUN;
         FS_RUN: begin
            req_valid = credit_ok & ~redir;
            if (redir) state_nxt = FS_REDIRECT;
         end
         FS_REDIRECT: state_nxt = FS_RUN;
         default: state_nxt = FS_BOOT;
      endcase
   end

   assign req_fire = req_valid & imem.imem_req_ready;
   assign rsp_drop = imem.imem_rsp_valid & (drop_cnt != '0);
   assign push     = imem.imem_rsp_valid & ~rsp_drop;

   assign inflight_nxt =
      inflight + CW'(req_fire) - CW'(imem.imem_rsp_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FS_BOOT;
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= inflight_nxt;
         if (redir) begin
            fetch_pc <= word_align(pc_target);
            rsp_pc   <= word_align(pc_target);
            // Everything still outstanding is wrong-path.
            drop_cnt <= inflight_nxt;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (push)     rsp_pc   <= rsp_pc + 32'd4;
            if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = fetch_pc;

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  ('{pc: rsp_pc, instr: imem.imem_rsp_data}),
      .pop        (pop),
      .flush      (redir),
      .head_valid (instr_valid),
      .head       (head),
      .count      (fifo_count)
   );

   assign instr          = head.instr;
   assign instr_pc       = head.pc;
   assign instr_pc_plus4 = head.pc + 32'd4;
   assign opcode         = head.instr[OPC_MSB:OPC_LSB];
   assign funct3         = head.instr[F3_MSB:F3_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a random
// stream checked against a program-order PC model and a memory model.
module tb_fetch_unit;
   import core_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_src;
   logic        instr_ready;
   logic [31:0] pc_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
   logic [6:0]  opcode;
   logic [2:0]  funct3;

   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic [31:0] w_pc4;
   logic [6:0]  w_opc;
   logic [2:0]  w_f3;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit mem_rnd = 1'b0;
   int mem_lat = 0;

   logic [31:0] q_addr[$];
   int          q_due[$];
   logic [31:0] log_pc[$];

   always #5 clk = ~clk;

   fetch_unit_if bus();
   fetch_unit_if wbus();

   fetch_unit #(
      .RESET_PC  (RST_PC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem           (bus),
      .pc_src         (pc_src),
      .pc_target      (pc_target),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_pc_plus4 (instr_pc_plus4),
      .opcode         (opcode),
      .funct3         (funct3),
      .instr_ready    (instr_ready)
   );

   fetch_unit #(
      .RESET_PC  (32'hFFFF_FFFC),
      .BUF_DEPTH (DEPTH)
   ) dut_w (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem           (wbus),
      .pc_src         (1'b0),
      .pc_target      (32'h0),
      .instr_valid    (w_valid),
      .instr          (w_instr),
      .instr_pc       (w_pc),
      .instr_pc_plus4 (w_pc4),
      .opcode         (w_opc),
      .funct3         (w_f3),
      .instr_ready    (1'b0)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   // Memory: in-order responses, at least one cycle after acceptance.
   initial begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
         if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            bus.imem_req_ready = 1'b0;
         end else begin
            bus.imem_req_ready = mem_rnd ? ($urandom_range(2) != 0) : 1'b1;
            if (q_addr.size() > 0 && q_due[0] <= cyc &&
                (!mem_rnd || $urandom_range(3) != 0)) begin
               bus.imem_rsp_valid = 1'b1;
               bus.imem_rsp_data  = mem_word(q_addr[0]);
               void'(q_addr.pop_front());
               void'(q_due.pop_front());
            end
            #2;
            if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
               q_addr.push_back(bus.imem_req_addr);
               q_due.push_back(cyc + 1 +
                  (mem_rnd ? int'($urandom_range(mem_lat)) : mem_lat));
            end
         end
      end
   end

   // Program-order model: the decoder must see RESET_PC, then +4 per
   // consumed word, or the aligned target after a taken redirect.
   initial begin
      logic        pend_q;
      logic [31:0] pend_a;
      logic        hold_q;
      logic        rd;
      logic [31:0] exp_pc;
      logic [31:0] exp_req;
      pend_q  = 1'b0;
      pend_a  = '0;
      hold_q  = 1'b0;
      exp_pc  = RST_PC;
      exp_req = RST_PC;
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            pend_q  = 1'b0;
            hold_q  = 1'b0;
            exp_pc  = RST_PC;
            exp_req = RST_PC;
            log_pc.delete();
            continue;
         end
         rd = instr_valid & instr_ready & pc_src;
         if (hold_q) begin
            checks++;
            if (instr_valid !== 1'b1) begin
               errors++;
               $display("FAIL head_held: valid=%b required=1", instr_valid);
            end
         end
         if (instr_valid === 1'b1) begin
            checks++;
            if (instr_pc !== exp_pc) begin
               errors++;
               $display("FAIL stream_pc: got=%h required=%h",
                        instr_pc, exp_pc);
            end
            checks++;
            if (instr !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL stream_data: got=%h required=%h",
                        instr, mem_word(exp_pc));
            end
            checks++;
            if ({opcode, funct3, instr_pc_plus4} !==
                {mem_word(exp_pc)[6:0], mem_word(exp_pc)[14:12],
                 exp_pc + 32'd4}) begin
               errors++;
               $display("FAIL fields: opc=%h f3=%h pc4=%h for pc=%h",
                        opcode, funct3, instr_pc_plus4, exp_pc);
            end
            if (instr_ready) begin
               log_pc.push_back(instr_pc);
               exp_pc = pc_src ? {pc_target[31:2], 2'b00} : exp_pc + 32'd4;
            end
         end
         hold_q = instr_valid & ~instr_ready;
         if (pend_q && !rd) begin
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== pend_a) begin
               errors++;
               $display("FAIL req_hold: valid=%b addr=%h required 1/%h",
                        bus.imem_req_valid, bus.imem_req_addr, pend_a);
            end
         end
         if (rd) begin
            checks++;
            if (bus.imem_req_valid !== 1'b0) begin
               errors++;
               $display("FAIL req_on_redirect: valid=%b required=0",
                        bus.imem_req_valid);
            end
         end
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            checks++;
            if (bus.imem_req_addr !== exp_req) begin
               errors++;
               $display("FAIL req_addr: got=%h required=%h",
                        bus.imem_req_addr, exp_req);
            end
            exp_req = exp_req + 32'd4;
         end
         if (rd) exp_req = {pc_target[31:2], 2'b00};
         pend_q = bus.imem_req_valid & ~bus.imem_req_ready & ~rd;
         pend_a = bus.imem_req_addr;
         checks++;
         if (q_addr.size() > DEPTH) begin
            errors++;
            $display("FAIL credit: outstanding=%0d max=%0d",
                     q_addr.size(), DEPTH);
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      mem_rnd = 1'b0;
      mem_lat = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({bus.imem_req_valid, instr_valid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_valid: req=%b instr=%b required 0/0",
                  bus.imem_req_valid, instr_valid);
      end
      checks++;
      if ({instr, instr_pc, opcode, funct3} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: instr=%h pc=%h opc=%h f3=%h required 0",
                  instr, instr_pc, opcode, funct3);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL boot_no_req: valid=%b required=0", bus.imem_req_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
         errors++;
         $display("FAIL first_req: valid=%b addr=%h required 1/%h",
                  bus.imem_req_valid, bus.imem_req_addr, RST_PC);
      end
      checks++;
      if (wbus.imem_req_valid !== 1'b1 || wbus.imem_req_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_first: valid=%b addr=%h required 1/fffffffc",
                  wbus.imem_req_valid, wbus.imem_req_addr);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC + 32'd4) begin
         errors++;
         $display("FAIL second_req: valid=%b addr=%h required 1/%h",
                  bus.imem_req_valid, bus.imem_req_addr, RST_PC + 32'd4);
      end
      checks++;
      if (wbus.imem_req_valid !== 1'b1 || wbus.imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_next: valid=%b addr=%h required 1/0",
                  wbus.imem_req_valid, wbus.imem_req_addr);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.imem_req_valid !== 1'b0 || wbus.imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL credit_stop: req=%b wreq=%b required 0/0",
                  bus.imem_req_valid, wbus.imem_req_valid);
      end
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== RST_PC) begin
         errors++;
         $display("FAIL first_word: valid=%b pc=%h required 1/%h",
                  instr_valid, instr_pc, RST_PC);
      end
   endtask

   task automatic test_stream();
      int n;
      @(negedge clk);
      instr_ready = 1'b1;
      n = 0;
      while (log_pc.size() < 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (log_pc.size() < 3) begin
         errors++;
         $display("FAIL stream_timeout: consumed=%0d required=3", log_pc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_pc[i] !== RST_PC + 32'(4 * i)) begin
               errors++;
               $display("FAIL stream_order[%0d]: got=%h required=%h",
                        i, log_pc[i], RST_PC + 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] hp;
      int          n0;
      @(negedge clk);
      instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      hp = instr_pc;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus.imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_req_stop: valid=%b required=0", bus.imem_req_valid);
      end
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== hp) begin
         errors++;
         $display("FAIL bp_head: valid=%b pc=%h required 1/%h",
                  instr_valid, instr_pc, hp);
      end
      n0 = log_pc.size();
      instr_ready = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (log_pc.size() < n0 + 5) begin
         errors++;
         $display("FAIL bp_resume: consumed=%0d required>=5", log_pc.size() - n0);
      end else begin
         checks++;
         if (log_pc[n0] !== hp) begin
            errors++;
            $display("FAIL bp_first_after: got=%h required=%h", log_pc[n0], hp);
         end
      end
   endtask

   task automatic test_redirect();
      int n;
      mem_lat = 3;
      @(negedge clk);
      instr_ready = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (instr_valid !== 1'b1 && n < 40);
      @(negedge clk);
      pc_src = 1'b1;
      instr_ready = 1'b1;
      pc_target = 32'h0000_0100;
      #1;
      checks++;
      if (instr_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_cycle: instr_valid=%b req=%b required 1/0",
                  instr_valid, bus.imem_req_valid);
      end
      @(negedge clk);
      pc_src = 1'b0;
      #1;
      checks++;
      if (bus.imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_bubble: req=%b instr_valid=%b required 0/0",
                  bus.imem_req_valid, instr_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
         errors++;
         $display("FAIL redir_req: valid=%b addr=%h required 1/100",
                  bus.imem_req_valid, bus.imem_req_addr);
      end
      n = 0;
      while (instr_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h100 ||
          instr !== mem_word(32'h100)) begin
         errors++;
         $display("FAIL redir_target: valid=%b pc=%h data=%h required pc=100",
                  instr_valid, instr_pc, instr);
      end
      mem_lat = 0;
   endtask

   task automatic test_collide();
      int n;
      bit hit;
      instr_ready = 1'b1;
      hit = 1'b0;
      n = 0;
      while (!hit && n < 40) begin
         @(negedge clk);
         #1;
         n++;
         hit = instr_valid & bus.imem_rsp_valid;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL collide_timeout: no push/pop overlap in %0d cycles", n);
      end else begin
         pc_src = 1'b1;
         pc_target = 32'h0000_0203;
         @(negedge clk);
         pc_src = 1'b0;
         #1;
         checks++;
         if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL collide_flush: instr_valid=%b required=0", instr_valid);
         end
         n = 0;
         while (instr_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
         end
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
            errors++;
            $display("FAIL collide_target: valid=%b pc=%h required 1/200",
                     instr_valid, instr_pc);
         end
      end
   endtask

   task automatic test_wrap();
      int n;
      int n0;
      instr_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (instr_valid !== 1'b1 && n < 40);
      pc_src = 1'b1;
      pc_target = 32'hFFFF_FFF8;
      @(negedge clk);
      pc_src = 1'b0;
      n0 = log_pc.size();
      n = 0;
      while (log_pc.size() < n0 + 3 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (log_pc.size() < n0 + 3) begin
         errors++;
         $display("FAIL wrap_timeout: consumed=%0d required=3", log_pc.size() - n0);
      end else begin
         checks++;
         if ({log_pc[n0], log_pc[n0+1], log_pc[n0+2]} !==
             {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000}) begin
            errors++;
            $display("FAIL wrap_seq: got=%h %h %h required fffffff8 fffffffc 0",
                     log_pc[n0], log_pc[n0+1], log_pc[n0+2]);
         end
      end
   endtask

   task automatic test_random();
      int n0;
      n0 = log_pc.size();
      mem_rnd = 1'b1;
      mem_lat = 3;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         instr_ready = ($urandom_range(3) != 0);
         pc_src = ($urandom_range(9) == 0);
         pc_target = $urandom;
      end
      @(negedge clk);
      pc_src = 1'b0;
      instr_ready = 1'b1;
      mem_rnd = 1'b0;
      mem_lat = 0;
      repeat (20) @(negedge clk);
      checks++;
      if (log_pc.size() < n0 + 50) begin
         errors++;
         $display("FAIL random_progress: consumed=%0d required>=50",
                  log_pc.size() - n0);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      instr_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (instr_valid !== 1'b1 && n < 40);
      instr_ready = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({instr_valid, bus.imem_req_valid, instr, instr_pc, opcode, funct3} !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b req=%b instr=%h pc=%h required 0",
                  instr_valid, bus.imem_req_valid, instr, instr_pc);
      end
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      instr_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (instr_valid !== 1'b1 && n < 40);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== RST_PC ||
          instr !== mem_word(RST_PC)) begin
         errors++;
         $display("FAIL restart: valid=%b pc=%h data=%h required pc=%h",
                  instr_valid, instr_pc, instr, RST_PC);
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      pc_src = 1'b0;
      instr_ready = 1'b0;
      pc_target = '0;
      wbus.imem_req_ready = 1'b1;
      wbus.imem_rsp_valid = 1'b0;
      wbus.imem_rsp_data = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_collide();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
